// File: rtl/eif_pkg.sv
// Shared types, default widths and arithmetic helpers for the EIF sweep scheduler.
package eif_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } eif_state_e;

  localparam int unsigned EIF_N_DEF          = 4;
  localparam int unsigned EIF_W_DEF          = 8;
  localparam int unsigned EIF_FIFO_DEPTH_DEF = 4;

  // Clamp an unsigned intermediate result to lim.
  function automatic int unsigned sat_max(input int unsigned v, input int unsigned lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/eif_step.sv
// Combinational single-neuron exponential integrate-and-fire update.
// Intermediate arithmetic is carried in 32 bits so sums never wrap before saturation.
module eif_step
  import eif_pkg::*;
#(
  parameter int unsigned W            = EIF_W_DEF,
  parameter int unsigned RW           = 2,
  parameter int unsigned LEAK_SHIFT   = 3,
  parameter int unsigned EXP_KNEE     = 160,
  parameter int unsigned EXP_SHIFT    = 1,
  parameter int unsigned THRESH_BASE  = 200,
  parameter int unsigned THR_STEP     = 16,
  parameter int unsigned RESET_V      = 0,
  parameter int unsigned REFRAC_TICKS = 2
) (
  input  logic [W-1:0]  s,
  input  logic [W-1:0]  cur,
  input  logic [RW-1:0] refr,
  input  logic [W-1:0]  thr,
  output logic [W-1:0]  s_next_c,
  output logic [RW-1:0] refr_next_c,
  output logic [W-1:0]  thr_next_c,
  output logic          spike_c
);

  localparam int unsigned VMAX = (2 ** W) - 1;

  logic [31:0] s_u;
  logic [31:0] thr_u;
  logic [31:0] leak_u;
  logic [31:0] exp_u;
  logic [31:0] v_u;

  // Integrate, leak, add the exponential term, then resolve refractory/spike.
  always_comb begin
    s_u         = 32'(s);
    thr_u       = 32'(thr);
    leak_u      = s_u >> LEAK_SHIFT;
    exp_u       = (s_u > EXP_KNEE) ? ((s_u - EXP_KNEE) >> EXP_SHIFT) : 32'd0;
    v_u         = sat_max(s_u - leak_u + 32'(cur) + exp_u, VMAX);
    s_next_c    = s;
    refr_next_c = refr;
    thr_next_c  = thr;
    spike_c     = 1'b0;
    if (refr != '0) begin
      s_next_c    = W'(RESET_V);
      refr_next_c = refr - RW'(1);
    end else if (v_u >= thr_u) begin
      spike_c     = 1'b1;
      s_next_c    = W'(RESET_V);
      refr_next_c = RW'(REFRAC_TICKS);
      thr_next_c  = W'(sat_max(thr_u + THR_STEP, VMAX));
    end else begin
      s_next_c = W'(v_u);
      if (thr_u > THRESH_BASE) thr_next_c = thr - W'(1);
    end
  end

endmodule

// File: rtl/eif_sweep_scheduler.sv
// Time-multiplexed EIF neuron population: per-neuron banks, sweep FSM, spike FIFO.
// Optional build macro EIF_ADAPT_THR_EN adds a per-neuron adaptive threshold bank.
module eif_sweep_scheduler
  import eif_pkg::*;
#(
  parameter int unsigned N_NEURONS    = EIF_N_DEF,
  parameter int unsigned W            = EIF_W_DEF,
  parameter int unsigned LEAK_SHIFT   = 3,
  parameter int unsigned EXP_KNEE     = 160,
  parameter int unsigned EXP_SHIFT    = 1,
  parameter int unsigned THRESH_BASE  = 200,
  parameter int unsigned THR_STEP     = 16,
  parameter int unsigned RESET_V      = 0,
  parameter int unsigned REFRAC_TICKS = 2,
  parameter int unsigned FIFO_DEPTH   = EIF_FIFO_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tick_i,
  input  logic                         cur_we_i,
  input  logic [$clog2(N_NEURONS)-1:0] cur_addr_i,
  input  logic [W-1:0]                 cur_data_i,
  input  logic [$clog2(N_NEURONS)-1:0] mon_sel_i,
  output logic [W-1:0]                 state_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         spike_valid_o,
  output logic [$clog2(N_NEURONS)-1:0] spike_id_o,
  input  logic                         spike_ready_i,
  output logic                         overflow_o
);

  localparam int unsigned AW  = $clog2(N_NEURONS);
  localparam int unsigned RW  = (REFRAC_TICKS < 1) ? 1 : $clog2(REFRAC_TICKS + 1);
  localparam int unsigned FAW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = FAW + 1;

  eif_state_e    st_q, st_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          tick_miss_c;

  logic [W-1:0]  state_q [N_NEURONS];
  logic [W-1:0]  cur_q   [N_NEURONS];
  logic [RW-1:0] refr_q  [N_NEURONS];

  logic [W-1:0]  thr_cur_c;
  logic [W-1:0]  s_next_c;
  logic [RW-1:0] refr_next_c;
  logic [W-1:0]  thr_next_c;
  logic          spike_c;
  logic          upd_en_c;

  logic [AW-1:0]  fifo_q [FIFO_DEPTH];
  logic [FAW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]  head_d;
  logic           pop_c, full_c, push_c, push_ok_c, drop_c;

  // Sweep FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= ST_IDLE;
      idx_q <= '0;
    end else begin
      st_q  <= st_d;
      idx_q <= idx_d;
    end
  end

  // Sweep FSM next state; ticks arriving mid-sweep are flagged as missed.
  always_comb begin
    st_d        = st_q;
    idx_d       = idx_q;
    tick_miss_c = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (tick_i) begin
          st_d  = ST_RUN;
          idx_d = '0;
        end
      end
      ST_RUN: begin
        tick_miss_c = tick_i;
        if (idx_q == AW'(N_NEURONS - 1)) st_d = ST_DONE;
        else idx_d = idx_q + AW'(1);
      end
      ST_DONE: begin
        tick_miss_c = tick_i;
        st_d        = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  assign upd_en_c = (st_q == ST_RUN);

  eif_step #(
    .W           (W),
    .RW          (RW),
    .LEAK_SHIFT  (LEAK_SHIFT),
    .EXP_KNEE    (EXP_KNEE),
    .EXP_SHIFT   (EXP_SHIFT),
    .THRESH_BASE (THRESH_BASE),
    .THR_STEP    (THR_STEP),
    .RESET_V     (RESET_V),
    .REFRAC_TICKS(REFRAC_TICKS)
  ) u_step (
    .s          (state_q[idx_q]),
    .cur        (cur_q[idx_q]),
    .refr       (refr_q[idx_q]),
    .thr        (thr_cur_c),
    .s_next_c   (s_next_c),
    .refr_next_c(refr_next_c),
    .thr_next_c (thr_next_c),
    .spike_c    (spike_c)
  );

  // Membrane, refractory and current banks; the current write lands after the read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_NEURONS); i++) begin
        state_q[i] <= W'(RESET_V);
        cur_q[i]   <= '0;
        refr_q[i]  <= '0;
      end
    end else begin
      if (upd_en_c) begin
        state_q[idx_q] <= s_next_c;
        refr_q[idx_q]  <= refr_next_c;
      end
      if (cur_we_i) cur_q[cur_addr_i] <= cur_data_i;
    end
  end

`ifdef EIF_ADAPT_THR_EN
  logic [W-1:0] thr_q [N_NEURONS];

  assign thr_cur_c = thr_q[idx_q];

  // Adaptive threshold bank: raised on spike, relaxes toward the resting value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_NEURONS); i++) thr_q[i] <= W'(THRESH_BASE);
    end else if (upd_en_c) begin
      thr_q[idx_q] <= thr_next_c;
    end
  end
`else
  logic unused_thr;

  assign thr_cur_c  = W'(THRESH_BASE);
  assign unused_thr = ^thr_next_c;
`endif

  // Spike FIFO control; a pop frees the slot for a same-cycle push when full.
  always_comb begin
    pop_c     = spike_ready_i && spike_valid_o;
    full_c    = (cnt_q == CW'(FIFO_DEPTH));
    push_c    = upd_en_c && spike_c;
    push_ok_c = push_c && (!full_c || pop_c);
    drop_c    = push_c && full_c && !pop_c;
    rd_ptr_d  = pop_c ? rd_ptr_q + FAW'(1) : rd_ptr_q;
    wr_ptr_d  = push_ok_c ? wr_ptr_q + FAW'(1) : wr_ptr_q;
    cnt_d     = cnt_q + CW'(push_ok_c) - CW'(pop_c);
    head_d    = fifo_q[rd_ptr_d];
    if (push_ok_c && (wr_ptr_q == rd_ptr_d)) head_d = idx_q;
    if (cnt_d == '0) head_d = '0;
  end

  // FIFO storage, pointers and registered head/valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      cnt_q         <= '0;
      spike_valid_o <= 1'b0;
      spike_id_o    <= '0;
    end else begin
      if (push_ok_c) fifo_q[wr_ptr_q] <= idx_q;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      cnt_q         <= cnt_d;
      spike_valid_o <= (cnt_d != '0);
      spike_id_o    <= head_d;
    end
  end

  // Status outputs, sticky overflow and membrane monitor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      overflow_o <= 1'b0;
      state_o    <= '0;
    end else begin
      busy_o     <= (st_d != ST_IDLE);
      done_o     <= (st_d == ST_DONE);
      overflow_o <= overflow_o | drop_c | tick_miss_c;
      state_o    <= state_q[mon_sel_i];
    end
  end

endmodule
